// File: rtl/aoi211_pkg.sv
// Shared defaults and helper functions for the pipelined AOI211 array.
// Functions operate on AOI211_MAX_W-bit vectors; callers zero-extend and truncate.
package aoi211_pkg;

    localparam int unsigned AOI211_WIDTH  = 8;
    localparam int unsigned AOI211_STAGES = 2;
    localparam int unsigned AOI211_CNT_W  = 16;

    localparam int unsigned AOI211_MAX_W  = 128;
    localparam int unsigned AOI211_POP_W  = $clog2(AOI211_MAX_W + 1);

    function automatic logic [AOI211_MAX_W-1:0] aoi211_f(
        input logic [AOI211_MAX_W-1:0] a,
        input logic [AOI211_MAX_W-1:0] b,
        input logic [AOI211_MAX_W-1:0] c1,
        input logic [AOI211_MAX_W-1:0] c2
    );
        return ~(a | b | (c1 & c2));
    endfunction

    function automatic logic [AOI211_POP_W-1:0] popcount(
        input logic [AOI211_MAX_W-1:0] v
    );
        logic [AOI211_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(AOI211_MAX_W); i++) begin
            n = n + AOI211_POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/aoi211_pipe_slot.sv
// One pipeline slot: valid bit plus data register with load enable.
// Data is only overwritten when a valid beat is loaded; bubbles keep old data.
module aoi211_pipe_slot
    import aoi211_pkg::*;
#(
    parameter int unsigned WIDTH = AOI211_WIDTH
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             i_load,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/aoi211_pipe.sv
// Pipelined, back-pressurable AOI211 array: ZN = ~(A | B | (C1 & C2)).
// Optional output toggle counter enabled by defining AOI211_TOGGLE_CNT_EN.
module aoi211_pipe
    import aoi211_pkg::*;
#(
    parameter int unsigned WIDTH  = AOI211_WIDTH,
    parameter int unsigned STAGES = AOI211_STAGES,
    parameter int unsigned CNT_W  = AOI211_CNT_W
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C1,
    input  logic [WIDTH-1:0] C2,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] ZN,
    output logic             OUT_VALID,
    input  logic             OUT_READY
`ifdef AOI211_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] TGL_CNT,
    input  logic             CNT_CLR
`endif
);

    if (WIDTH < 1 || WIDTH > AOI211_MAX_W) begin : g_bad_width
        $error("aoi211_pipe: WIDTH out of range");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("aoi211_pipe: STAGES must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("aoi211_pipe: CNT_W must be at least 1");
    end

    // Index 0 is the input beat; index i+1 is the output of slot i.
    logic [STAGES:0] w_vld;
    logic [STAGES:0] w_rdy;
    logic [WIDTH-1:0] w_data [STAGES+1];

    assign w_vld[0]  = IN_VALID;
    assign w_data[0] = WIDTH'(aoi211_f(AOI211_MAX_W'(A), AOI211_MAX_W'(B),
                                       AOI211_MAX_W'(C1), AOI211_MAX_W'(C2)));

    // A slot can load if it is empty or its successor is loading.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = OUT_READY;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_vld[i+1] | w_rdy[i+1];
        end
    end

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_slot
        aoi211_pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .CK     (CK),
            .RST    (RST),
            .i_load (w_rdy[g]),
            .i_vld  (w_vld[g]),
            .i_data (w_data[g]),
            .o_vld  (w_vld[g+1]),
            .o_data (w_data[g+1])
        );
    end

    assign IN_READY  = w_rdy[0];
    assign OUT_VALID = w_vld[STAGES];
    assign ZN        = w_data[STAGES];

`ifdef AOI211_TOGGLE_CNT_EN
    localparam int unsigned SUM_W = CNT_W + AOI211_POP_W;

    logic [WIDTH-1:0]        r_last_zn;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_hs;
    logic [AOI211_POP_W-1:0] w_pop;
    logic [SUM_W-1:0]        w_sum;
    logic [SUM_W-1:0]        w_cnt_max;
    logic [CNT_W-1:0]        w_cnt_next;

    assign w_hs       = OUT_VALID & OUT_READY;
    assign w_pop      = popcount(AOI211_MAX_W'(ZN ^ r_last_zn));
    assign w_sum      = SUM_W'(r_cnt) + SUM_W'(w_pop);
    assign w_cnt_max  = SUM_W'({CNT_W{1'b1}});
    assign w_cnt_next = (w_sum > w_cnt_max) ? {CNT_W{1'b1}} : CNT_W'(w_sum);

    // Clear beats a same-cycle handshake, but the reference value still advances.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_last_zn <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_hs) begin
                r_last_zn <= ZN;
            end
            if (CNT_CLR) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign TGL_CNT = r_cnt;
`endif

endmodule

// File: tb/tb_aoi211_pipe.sv
// Directed and randomized checks of aoi211_pipe (WIDTH=4, STAGES=2, CNT_W=4).
// Toggle-counter scenario runs only when AOI211_TOGGLE_CNT_EN is defined.
module tb_aoi211_pipe;

    localparam int unsigned W = 4;
    localparam int unsigned S = 2;

    logic         CK = 1'b0;
    logic         RST;
    logic [W-1:0] A, B, C1, C2;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] ZN;
    logic         OUT_VALID;
    logic         OUT_READY;
`ifdef AOI211_TOGGLE_CNT_EN
    logic [3:0]   TGL_CNT;
    logic         CNT_CLR;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CK = ~CK;

    aoi211_pipe #(
        .WIDTH  (W),
        .STAGES (S),
        .CNT_W  (4)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .C1        (C1),
        .C2        (C2),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ZN        (ZN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
`ifdef AOI211_TOGGLE_CNT_EN
        ,
        .TGL_CNT   (TGL_CNT),
        .CNT_CLR   (CNT_CLR)
`endif
    );

    task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c1, input logic [W-1:0] c2,
                            input logic v);
        A = a; B = b; C1 = c1; C2 = c2; IN_VALID = v;
    endtask

    task automatic test_reset();
        RST = 1'b1; OUT_READY = 1'b1;
        set_beat(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge CK);
        #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", OUT_VALID); end
        n_checks++; if (ZN !== 4'h0) begin n_fail++; $display("FAIL rst_zn: got %h want 0", ZN); end
`ifdef AOI211_TOGGLE_CNT_EN
        n_checks++; if (TGL_CNT !== 4'h0) begin n_fail++; $display("FAIL rst_tgl_cnt: got %0d want 0", TGL_CNT); end
`endif
        @(negedge CK); RST = 1'b0; #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", IN_READY); end
    endtask

    task automatic test_latency();
        @(negedge CK); OUT_READY = 1'b1; set_beat(4'h0, 4'h0, 4'h5, 4'h3, 1'b1); #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL lat_accept: got %b want 1", IN_READY); end
        @(negedge CK); IN_VALID = 1'b0; #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", OUT_VALID); end
        @(negedge CK); #1;
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b want 1", OUT_VALID); end
        n_checks++; if (ZN !== 4'hE) begin n_fail++; $display("FAIL lat_zn: got %h want e", ZN); end
        @(negedge CK); #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL lat_after: got %b want 0", OUT_VALID); end
    endtask

    task automatic test_back_to_back();
        @(negedge CK); OUT_READY = 1'b1; set_beat(4'h0, 4'h0, 4'hF, 4'hF, 1'b1);
        @(negedge CK); set_beat(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge CK); IN_VALID = 1'b0; #1;
        n_checks++; if (OUT_VALID !== 1'b1 || ZN !== 4'h0) begin n_fail++; $display("FAIL b2b_first: got v=%b zn=%h want v=1 zn=0", OUT_VALID, ZN); end
        @(negedge CK); #1;
        n_checks++; if (OUT_VALID !== 1'b1 || ZN !== 4'hF) begin n_fail++; $display("FAIL b2b_second: got v=%b zn=%h want v=1 zn=f", OUT_VALID, ZN); end
        @(negedge CK); #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", OUT_VALID); end
    endtask

    task automatic test_stall();
        @(negedge CK); OUT_READY = 1'b0; set_beat(4'h1, 4'h0, 4'h0, 4'h0, 1'b1); #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL stall_acc1: got %b want 1", IN_READY); end
        @(negedge CK); set_beat(4'h2, 4'h0, 4'h0, 4'h0, 1'b1); #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL stall_acc2: got %b want 1", IN_READY); end
        @(negedge CK); set_beat(4'h4, 4'h0, 4'h0, 4'h0, 1'b1); #1;
        n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL stall_full: got %b want 0", IN_READY); end
        n_checks++; if (OUT_VALID !== 1'b1 || ZN !== 4'hE) begin n_fail++; $display("FAIL stall_head: got v=%b zn=%h want v=1 zn=e", OUT_VALID, ZN); end
        @(negedge CK); #1;
        n_checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || ZN !== 4'hE) begin n_fail++; $display("FAIL stall_hold: got r=%b v=%b zn=%h want r=0 v=1 zn=e", IN_READY, OUT_VALID, ZN); end
        @(negedge CK); OUT_READY = 1'b1; #1;
        n_checks++; if (IN_READY !== 1'b1 || ZN !== 4'hE) begin n_fail++; $display("FAIL stall_release: got r=%b zn=%h want r=1 zn=e", IN_READY, ZN); end
        @(negedge CK); IN_VALID = 1'b0; #1;
        n_checks++; if (OUT_VALID !== 1'b1 || ZN !== 4'hD) begin n_fail++; $display("FAIL stall_beat2: got v=%b zn=%h want v=1 zn=d", OUT_VALID, ZN); end
        @(negedge CK); #1;
        n_checks++; if (OUT_VALID !== 1'b1 || ZN !== 4'hB) begin n_fail++; $display("FAIL stall_beat3: got v=%b zn=%h want v=1 zn=b", OUT_VALID, ZN); end
        @(negedge CK); #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", OUT_VALID); end
    endtask

    task automatic test_reset_midstream();
        @(negedge CK); OUT_READY = 1'b0; set_beat(4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge CK); set_beat(4'h2, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge CK); IN_VALID = 1'b0; #1;
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_loaded: got %b want 1", OUT_VALID); end
        RST = 1'b1; #1;
        n_checks++; if (OUT_VALID !== 1'b0 || ZN !== 4'h0) begin n_fail++; $display("FAIL mid_async: got v=%b zn=%h want v=0 zn=0", OUT_VALID, ZN); end
        @(negedge CK); RST = 1'b0; OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CK); #1;
            n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", i, OUT_VALID); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] a, b, c1, c2, exp_zn, exp_head;
        logic         exp_rdy;
        int           guard;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge CK);
            a = W'($urandom); b = W'($urandom); c1 = W'($urandom); c2 = W'($urandom);
            set_beat(a, b, c1, c2, ($urandom_range(0, 2) != 0));
            OUT_READY = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() < S) || OUT_READY;
            n_checks++; if (IN_READY !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, IN_READY, exp_rdy); end
            if (OUT_VALID && OUT_READY) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra@%0d: got zn=%h want no beat", cyc, ZN);
                end else begin
                    exp_head = q.pop_front();
                    if (ZN !== exp_head) begin n_fail++; $display("FAIL rnd_zn@%0d: got %h want %h", cyc, ZN, exp_head); end
                end
            end
            if (IN_VALID && IN_READY) begin
                exp_zn = ~(a | b | (c1 & c2));
                q.push_back(exp_zn);
            end
        end
        @(negedge CK); IN_VALID = 1'b0; OUT_READY = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            #1;
            if (OUT_VALID) begin
                exp_head = q.pop_front();
                n_checks++; if (ZN !== exp_head) begin n_fail++; $display("FAIL rnd_drain_zn: got %h want %h", ZN, exp_head); end
            end
            @(negedge CK);
            guard++;
        end
        #1;
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d beats missing want 0", q.size()); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rnd_dup: got out_valid=%b want 0", OUT_VALID); end
    endtask

`ifdef AOI211_TOGGLE_CNT_EN
    task automatic test_toggle_cnt();
        logic [W-1:0] seq_a [5];
        seq_a[0] = 4'h0; seq_a[1] = 4'hF; seq_a[2] = 4'h0; seq_a[3] = 4'hF; seq_a[4] = 4'h0;
        CNT_CLR = 1'b0;
        @(negedge CK); RST = 1'b1; @(negedge CK); RST = 1'b0; OUT_READY = 1'b1; #1;
        n_checks++; if (TGL_CNT !== 4'd0) begin n_fail++; $display("FAIL tgl_reset: got %0d want 0", TGL_CNT); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CK); set_beat(seq_a[i], 4'h0, 4'h0, 4'h0, 1'b1);
        end
        @(negedge CK); IN_VALID = 1'b0;
        repeat (3) @(negedge CK);
        #1;
        n_checks++; if (TGL_CNT !== 4'd15) begin n_fail++; $display("FAIL tgl_saturate: got %0d want 15", TGL_CNT); end
        @(negedge CK); CNT_CLR = 1'b1;
        @(negedge CK); CNT_CLR = 1'b0; #1;
        n_checks++; if (TGL_CNT !== 4'd0) begin n_fail++; $display("FAIL tgl_clear: got %0d want 0", TGL_CNT); end
        // last_zn is 0xF; 0xE flips one bit
        @(negedge CK); set_beat(4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge CK); IN_VALID = 1'b0;
        repeat (2) @(negedge CK);
        #1;
        n_checks++; if (TGL_CNT !== 4'd1) begin n_fail++; $display("FAIL tgl_one_bit: got %0d want 1", TGL_CNT); end
        // clear coincides with the 0x1 handshake; last_zn must still become 0x1
        @(negedge CK); set_beat(4'hE, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge CK); IN_VALID = 1'b0;
        @(negedge CK); CNT_CLR = 1'b1; #1;
        n_checks++; if (OUT_VALID !== 1'b1 || ZN !== 4'h1) begin n_fail++; $display("FAIL tgl_clr_hs_setup: got v=%b zn=%h want v=1 zn=1", OUT_VALID, ZN); end
        @(negedge CK); CNT_CLR = 1'b0; #1;
        n_checks++; if (TGL_CNT !== 4'd0) begin n_fail++; $display("FAIL tgl_clr_wins: got %0d want 0", TGL_CNT); end
        @(negedge CK); set_beat(4'hC, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge CK); IN_VALID = 1'b0;
        repeat (2) @(negedge CK);
        #1;
        n_checks++; if (TGL_CNT !== 4'd1) begin n_fail++; $display("FAIL tgl_last_upd: got %0d want 1", TGL_CNT); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AOI211_TOGGLE_CNT_EN
        CNT_CLR = 1'b0;
`endif
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_random();
`ifdef AOI211_TOGGLE_CNT_EN
        test_toggle_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aoi211_pipe.md
Name: aoi211_pipe

Overview:
Parametrised, pipelined successor to the single-bit AOI211 cell. Computes ZN = ~(A | B | (C1 & C2)) bitwise over WIDTH-bit vectors. Registers the result through STAGES pipeline slots with a valid/ready handshake and bubble collapsing. Used in cell-library characterisation and datapath test harnesses where a clocked, back-pressurable AOI211 array is needed.

Parameters:
- WIDTH, 8: bit width of A, B, C1, C2 and ZN; must be at least 1.
- STAGES, 2: number of register slots between input and output; must be at least 1.
- CNT_W, 16: toggle-counter width; used only when AOI211_TOGGLE_CNT_EN is defined.

Ports:
- CK  input  1  clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  WIDTH  OR term.
- B  input  WIDTH  OR term.
- C1  input  WIDTH  AND term.
- C2  input  WIDTH  AND term.
- IN_VALID  input  1  A/B/C1/C2 hold a valid beat.
- IN_READY  output  1  block accepts the beat this cycle.
- ZN  output  WIDTH  registered AOI211 result.
- OUT_VALID  output  1  ZN holds a valid beat.
- OUT_READY  input  1  downstream accepts ZN this cycle.
- TGL_CNT  output  CNT_W  toggle count; present only with AOI211_TOGGLE_CNT_EN.
- CNT_CLR  input  1  synchronous counter clear; present only with AOI211_TOGGLE_CNT_EN.

Behaviour:
- Clock and reset are CK and RST. There is one clock. Reset is asynchronous and active-high.
- Reset state: every stage valid = 0 and every stage data = 0. Therefore OUT_VALID = 0, ZN = 0 and TGL_CNT = 0. IN_READY = 1 once RST deasserts.
- The function is evaluated combinationally on the input beat and captured into slot 0. Slots 1..STAGES-1 forward the data unchanged. ZN and OUT_VALID are driven directly by the last slot's data and valid.
- Per-slot ready: rdy[i] = ~vld[i] | rdy[i+1], with rdy[STAGES] = OUT_READY. IN_READY = rdy[0], which is combinational from OUT_READY.
- Slot i loads when rdy[i] = 1. On load: vld[i] <= vld[i-1] (IN_VALID for i = 0) and data[i] <= data[i-1]. Slot data is written only when the incoming valid is 1; a bubble load leaves data unchanged.
- Latency: an accepted beat appears on ZN exactly STAGES cycles after the accepting edge when OUT_READY = 1 throughout. Throughput is one beat per cycle.
- Stall: while OUT_VALID = 1 and OUT_READY = 0, ZN and OUT_VALID hold stable. Upstream bubbles collapse, so up to STAGES beats can be buffered. IN_READY = 0 only when all slots are valid and OUT_READY = 0.
- Simultaneous accept and emit with a full pipeline and OUT_READY = 1: the shift completes and no beat is lost or duplicated.
- IN_VALID with IN_READY = 0: the beat is not taken. The source must hold it.
- RST asserted mid-operation: all in-flight beats are discarded immediately (asynchronously). No partial beat is emitted afterwards.
- There is no data-dependent state and no arithmetic beyond bitwise logic.

Optional Feature:
- Macro AOI211_TOGGLE_CNT_EN.
- Defined: TGL_CNT and CNT_CLR ports exist. On each output handshake (OUT_VALID & OUT_READY), TGL_CNT adds popcount(ZN ^ last_zn), then last_zn <= ZN.
  - last_zn resets to 0.
  - The counter saturates at 2^CNT_W - 1 and does not wrap.
  - CNT_CLR zeroes the counter. If CNT_CLR and a handshake occur in the same cycle, CNT_CLR wins, but last_zn still updates.
- Undefined: the ports, counter and last_zn are absent. Datapath behaviour is identical.

Decomposition:
- Package aoi211_pkg holds:
  - function aoi211_f(a, b, c1, c2), returning ~(a | b | (c1 & c2));
  - localparam defaults for WIDTH, STAGES and CNT_W;
  - a popcount function.
- Sub-module aoi211_pipe_slot: one valid/data register with load enable and async reset. It is instantiated STAGES times via generate.

Test Plan:
- WIDTH=4, STAGES=2, OUT_READY=1. Beat A=0, B=0, C1=0x5, C2=0x3 -> ZN=0xE with OUT_VALID=1 exactly 2 cycles after acceptance.
- Beats {A=0, B=0, C1=0xF, C2=0xF} then {all 0} back-to-back -> ZN=0x0 then 0xF on consecutive cycles.
- OUT_READY=0 with 3 beats offered -> 2 accepted, IN_READY=0 on the third, ZN held. Release OUT_READY -> all beats emitted in order with none dropped.
- Pulse RST mid-stream with 2 beats in flight -> OUT_VALID=0 and ZN=0 immediately. No stale beat appears after release.
- AOI211_TOGGLE_CNT_EN, CNT_W=4: emit ZN 0xF, 0x0, 0xF, 0x0, 0xF -> TGL_CNT saturates at 15, not 0/wrapped. CNT_CLR -> 0.
- Random IN_VALID/OUT_READY over 10k cycles: a scoreboard checks order, values, and that no beat is lost or duplicated.
